// File: rtl/iaoq_unit.sv
// rtl/iaoq_unit.sv - two-entry instruction address offset queue for the fetch stage
//
// Purpose: holds the IAOQ front (address being fetched) and back (next address),
// with delayed-branch advance, stall, trap entry with IIAOQ save, return from
// interrupt, and sticky double-fault detection.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   le           advance enable (0 = stall)
//   br_taken     branch resolved taken this cycle
//   br_target    branch target address
//   trap         exception/interrupt request (not stallable)
//   rfi          return-from-interrupt
//   front        IAOQ front
//   back         IAOQ back
//   iiaoq_front  front captured at trap entry
//   iiaoq_back   back captured at trap entry
//   in_trap      1 while in TRAP state
//   dbl_fault    sticky; trap taken while already in TRAP
module iaoq_unit #(
  parameter int              AW         = 32,
  parameter int              INC        = 4,
  parameter logic [AW-1:0]   RESET_VEC  = '0,
  parameter logic [AW-1:0]   TRAP_VEC   = AW'('h100),
  parameter int              ALIGN_BITS = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          le,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          trap,
  input  logic          rfi,
  output logic [AW-1:0] front,
  output logic [AW-1:0] back,
  output logic [AW-1:0] iiaoq_front,
  output logic [AW-1:0] iiaoq_back,
  output logic          in_trap,
  output logic          dbl_fault
);

  localparam logic [AW-1:0] INC_W      = AW'(INC);
  // Additions are modulo 2^AW by construction of the AW-bit result.
  localparam logic [AW-1:0] RESET_NEXT = RESET_VEC + INC_W;
  localparam logic [AW-1:0] TRAP_NEXT  = TRAP_VEC + INC_W;
  localparam logic [AW-1:0] ALIGN_MASK = ~(AW'((64'd1 << ALIGN_BITS) - 64'd1));

  typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_t;

  state_t        state, state_next;
  logic [AW-1:0] front_next, back_next;
  logic [AW-1:0] iiaoq_front_next, iiaoq_back_next;
  logic          dbl_next;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      front       <= RESET_VEC;
      back        <= RESET_NEXT;
      iiaoq_front <= '0;
      iiaoq_back  <= '0;
      dbl_fault   <= 1'b0;
    end else begin
      state       <= state_next;
      front       <= front_next;
      back        <= back_next;
      iiaoq_front <= iiaoq_front_next;
      iiaoq_back  <= iiaoq_back_next;
      dbl_fault   <= dbl_next;
    end
  end

  // Next-state: trap > rfi > br_taken > sequential; only trap ignores le.
  always_comb begin
    state_next       = state;
    front_next       = front;
    back_next        = back;
    iiaoq_front_next = iiaoq_front;
    iiaoq_back_next  = iiaoq_back;
    dbl_next         = dbl_fault;
    if (trap) begin
      front_next = TRAP_VEC;
      back_next  = TRAP_NEXT;
      state_next = S_TRAP;
      if (state == S_RUN) begin
        iiaoq_front_next = front;
        iiaoq_back_next  = back;
      end else begin
        // Nested trap: keep the original return point, flag the fault.
        dbl_next = 1'b1;
      end
    end else if (le) begin
      if (rfi && state == S_TRAP) begin
        front_next = iiaoq_front;
        back_next  = iiaoq_back;
        state_next = S_RUN;
      end else if (br_taken) begin
        // Delayed branch: old back still executes as the delay slot.
        front_next = back;
        back_next  = br_target & ALIGN_MASK;
      end else begin
        front_next = back;
        back_next  = back + INC_W;
      end
    end
  end

  // Outputs derived from the state register.
  always_comb begin
    in_trap = (state == S_TRAP);
  end

endmodule

// File: tb/tb_iaoq_unit.sv
// tb/tb_iaoq_unit.sv - directed self-checking bench for iaoq_unit
//
// Purpose: drives hand-computed vectors into a 32-bit and an 8-bit instance.
// Ports: none (top-level bench).
module tb_iaoq_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance stimulus and observation
  logic        reset, le, br_taken, trap, rfi;
  logic [31:0] br_target;
  logic [31:0] front, back, iiaoq_front, iiaoq_back;
  logic        in_trap, dbl_fault;

  // 8-bit instance stimulus and observation
  logic       reset8, le8, br8, trap8, rfi8;
  logic [7:0] tgt8;
  logic [7:0] front8, back8, ifront8, iback8;
  logic       in_trap8, dbl8;

  int n_checks = 0;
  int n_pass   = 0;

  iaoq_unit #(.AW(32), .INC(4), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .ALIGN_BITS(2)) dut (
    .clk(clk), .reset(reset), .le(le), .br_taken(br_taken), .br_target(br_target),
    .trap(trap), .rfi(rfi), .front(front), .back(back), .iiaoq_front(iiaoq_front),
    .iiaoq_back(iiaoq_back), .in_trap(in_trap), .dbl_fault(dbl_fault)
  );

  iaoq_unit #(.AW(8), .INC(4), .RESET_VEC(8'h0), .TRAP_VEC(8'h80), .ALIGN_BITS(2)) dut8 (
    .clk(clk), .reset(reset8), .le(le8), .br_taken(br8), .br_target(tgt8),
    .trap(trap8), .rfi(rfi8), .front(front8), .back(back8), .iiaoq_front(ifront8),
    .iiaoq_back(iback8), .in_trap(in_trap8), .dbl_fault(dbl8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [31:0] f, input logic [31:0] b);
    check({tag, ".front"}, front, f);
    check({tag, ".back"}, back, b);
  endtask

  task automatic chk_q8(input string tag, input logic [7:0] f, input logic [7:0] b);
    check({tag, ".front"}, 32'(front8), 32'(f));
    check({tag, ".back"}, 32'(back8), 32'(b));
  endtask

  initial begin
    reset = 1'b1; le = 1'b0; br_taken = 1'b0; br_target = '0; trap = 1'b0; rfi = 1'b0;
    reset8 = 1'b1; le8 = 1'b0; br8 = 1'b0; tgt8 = '0; trap8 = 1'b0; rfi8 = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk_q("rst", 32'h0, 32'h4);
    check("rst.iiaoq_front", iiaoq_front, 32'h0);
    check("rst.iiaoq_back", iiaoq_back, 32'h0);
    check("rst.in_trap", 32'(in_trap), 32'h0);
    check("rst.dbl_fault", 32'(dbl_fault), 32'h0);

    // Sequential advance
    le = 1'b1;
    step(); chk_q("seq1", 32'h4, 32'h8);
    step(); chk_q("seq2", 32'h8, 32'hc);

    // Delayed branch with unaligned target
    br_taken = 1'b1; br_target = 32'h203;
    step(); chk_q("br", 32'hc, 32'h200);
    br_taken = 1'b0;
    step(); chk_q("br_after", 32'h200, 32'h204);

    // Stall drops the held branch until le returns
    reset = 1'b1; step(); reset = 1'b0;
    chk_q("rst2", 32'h0, 32'h4);
    step(); chk_q("pre_stall", 32'h4, 32'h8);
    le = 1'b0; br_taken = 1'b1; br_target = 32'h303;
    step(); chk_q("stall1", 32'h4, 32'h8);
    step(); chk_q("stall2", 32'h4, 32'h8);
    le = 1'b1;
    step(); chk_q("stall_br", 32'h8, 32'h300);

    // Steer to (0x40, 0x44)
    br_target = 32'h40;
    step(); chk_q("br40", 32'h300, 32'h40);
    br_taken = 1'b0;
    step(); chk_q("at40", 32'h40, 32'h44);

    // Trap with le=0 still taken
    le = 1'b0; trap = 1'b1;
    step();
    trap = 1'b0;
    chk_q("trap", 32'h100, 32'h104);
    check("trap.iiaoq_front", iiaoq_front, 32'h40);
    check("trap.iiaoq_back", iiaoq_back, 32'h44);
    check("trap.in_trap", 32'(in_trap), 32'h1);
    check("trap.dbl_fault", 32'(dbl_fault), 32'h0);

    // rfi restores
    le = 1'b1; rfi = 1'b1;
    step();
    chk_q("rfi", 32'h40, 32'h44);
    check("rfi.in_trap", 32'(in_trap), 32'h0);

    // rfi in RUN is ignored; sequential advance proceeds
    step();
    rfi = 1'b0;
    chk_q("rfi_run", 32'h44, 32'h48);
    check("rfi_run.in_trap", 32'(in_trap), 32'h0);

    // Trap, then nested trap -> double fault
    trap = 1'b1;
    step();
    check("trap2.iiaoq_front", iiaoq_front, 32'h44);
    check("trap2.dbl_fault", 32'(dbl_fault), 32'h0);
    step();
    trap = 1'b0;
    chk_q("nest", 32'h100, 32'h104);
    check("nest.dbl_fault", 32'(dbl_fault), 32'h1);
    check("nest.iiaoq_front", iiaoq_front, 32'h44);
    check("nest.iiaoq_back", iiaoq_back, 32'h48);
    check("nest.in_trap", 32'(in_trap), 32'h1);

    // Handler advances, then trap+rfi+br together: trap wins
    step(); chk_q("handler", 32'h104, 32'h108);
    trap = 1'b1; rfi = 1'b1; br_taken = 1'b1; br_target = 32'h500;
    step();
    trap = 1'b0; br_taken = 1'b0;
    chk_q("trap_wins", 32'h100, 32'h104);
    check("trap_wins.in_trap", 32'(in_trap), 32'h1);
    check("trap_wins.iiaoq_front", iiaoq_front, 32'h44);

    // rfi returns; dbl_fault stays sticky
    step();
    rfi = 1'b0;
    chk_q("rfi2", 32'h44, 32'h48);
    check("rfi2.in_trap", 32'(in_trap), 32'h0);
    check("rfi2.dbl_fault", 32'(dbl_fault), 32'h1);

    // AW=8 wrap
    reset8 = 1'b0; le8 = 1'b1;
    chk_q8("w_rst", 8'h0, 8'h4);
    br8 = 1'b1; tgt8 = 8'd250;
    step(); chk_q8("w_br", 8'd4, 8'd248);
    br8 = 1'b0;
    step(); chk_q8("w_248", 8'd248, 8'd252);
    step(); chk_q8("w_wrap", 8'd252, 8'd0);
    step(); chk_q8("w_after", 8'd0, 8'd4);

    // Trap twice, then reset mid-trap
    trap8 = 1'b1;
    step();
    chk_q8("w_trap", 8'h80, 8'h84);
    check("w_trap.iiaoq_front", 32'(ifront8), 32'h0);
    check("w_trap.iiaoq_back", 32'(iback8), 32'h4);
    step();
    trap8 = 1'b0;
    check("w_nest.dbl_fault", 32'(dbl8), 32'h1);
    reset8 = 1'b1;
    step();
    reset8 = 1'b0;
    chk_q8("w_rst2", 8'h0, 8'h4);
    check("w_rst2.iiaoq_front", 32'(ifront8), 32'h0);
    check("w_rst2.iiaoq_back", 32'(iback8), 32'h0);
    check("w_rst2.in_trap", 32'(in_trap8), 32'h0);
    check("w_rst2.dbl_fault", 32'(dbl8), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
